// File: rtl/dsp_mem_stage_if.sv
// Handshake, operand, memory-bank and write-back signals of the DSP memory-access stage.
// master = pipeline/memory side, slave = dsp_mem_stage.
interface dsp_mem_stage_if #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 15,
  parameter int NUM_BANKS = 2
);
  logic                        in_valid;
  logic                        in_ready;
  logic [2:0]                  mem_mode;
  logic [DATA_W-1:0]           data_s1;
  logic [DATA_W-1:0]           data_s2;
  logic [DATA_W-1:0]           alu_result;
  logic                        wb_req;
  logic [NUM_BANKS-1:0]        mem_rd_en;
  logic [ADDR_W-1:0]           mem_rd_addr;
  logic [NUM_BANKS*DATA_W-1:0] mem_rd_data;
  logic [NUM_BANKS-1:0]        mem_wr_en;
  logic [ADDR_W-1:0]           mem_wr_addr;
  logic [DATA_W-1:0]           mem_wr_data;
  logic [DATA_W-1:0]           wb_data;
  logic                        rf_wr_en;
  logic                        err;

  modport master (
    output in_valid, mem_mode, data_s1, data_s2, alu_result, wb_req, mem_rd_data,
    input  in_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
           wb_data, rf_wr_en, err
  );

  modport slave (
    input  in_valid, mem_mode, data_s1, data_s2, alu_result, wb_req, mem_rd_data,
    output in_ready, mem_rd_en, mem_rd_addr, mem_wr_en, mem_wr_addr, mem_wr_data,
           wb_data, rf_wr_en, err
  );
endinterface

// File: rtl/dsp_mem_stage.sv
// Registered memory-access stage: NONE/LD/ST/LD_IMM/RMW_ADD over NUM_BANKS sync-read banks.
// Define DSP_MEM_PERF_CNT_EN to add the saturating perf_stall_cnt output.
module dsp_mem_stage #(
  parameter int DATA_W    = 16,
  parameter int ADDR_W    = 15,
  parameter int NUM_BANKS = 2
) (
  input  logic        clk,
  input  logic        rst,
  dsp_mem_stage_if.slave bus
`ifdef DSP_MEM_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt
`endif
);
  localparam int BANK_BITS = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 0;
  localparam int SEL_W     = (BANK_BITS > 0) ? BANK_BITS : 1;

  localparam logic [2:0] MODE_NONE = 3'd0;
  localparam logic [2:0] MODE_LD   = 3'd1;
  localparam logic [2:0] MODE_ST   = 3'd2;
  localparam logic [2:0] MODE_LDI  = 3'd3;
  localparam logic [2:0] MODE_RMW  = 3'd4;

  typedef enum logic [1:0] {IDLE, LD_WAIT, RMW_WAIT, RMW_WR} state_e;

  state_e               state_q;
  logic [SEL_W-1:0]     bankIn;
  logic [SEL_W-1:0]     bank_q;
  logic [ADDR_W-1:0]    addr_q;
  logic [DATA_W-1:0]    addend_q;
  logic [DATA_W-1:0]    rmwData_q;
  logic [NUM_BANKS-1:0] rmwWrEn_q;
  logic [DATA_W-1:0]    wbData_q;
  logic                 rfWrEn_q;
  logic                 err_q;
  logic                 accept;
  logic [NUM_BANKS-1:0] hotIn;
  logic [NUM_BANKS-1:0] hotQ;
  logic [DATA_W-1:0]    rdSel;
  logic [DATA_W-1:0]    sum;
  logic                 unusedS1;

  generate
    if (BANK_BITS > 0) begin : g_bank
      assign bankIn = bus.data_s1[ADDR_W +: BANK_BITS];
    end else begin : g_nobank
      assign bankIn = '0;
    end
  endgenerate

  assign unusedS1 = ^bus.data_s1;

  assign bus.in_ready = (state_q == IDLE) && !rst;
  assign accept       = bus.in_valid && bus.in_ready;
  assign hotIn        = NUM_BANKS'(1) << bankIn;
  assign hotQ         = NUM_BANKS'(1) << bank_q;
  assign rdSel        = bus.mem_rd_data[int'(bank_q)*DATA_W +: DATA_W];
  assign sum          = rdSel + addend_q;

  // Accept-cycle accesses are combinational; the RMW write comes from registers instead.
  assign bus.mem_rd_en   = (accept && (bus.mem_mode == MODE_LD || bus.mem_mode == MODE_RMW))
                           ? hotIn : '0;
  assign bus.mem_rd_addr = bus.data_s1[ADDR_W-1:0];
  assign bus.mem_wr_en   = (accept && bus.mem_mode == MODE_ST) ? hotIn : rmwWrEn_q;
  assign bus.mem_wr_addr = (state_q == RMW_WR) ? addr_q : bus.data_s1[ADDR_W-1:0];
  assign bus.mem_wr_data = (state_q == RMW_WR) ? rmwData_q : bus.data_s2;

  assign bus.wb_data  = wbData_q;
  assign bus.rf_wr_en = rfWrEn_q;
  assign bus.err      = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      bank_q    <= '0;
      addr_q    <= '0;
      addend_q  <= '0;
      rmwData_q <= '0;
      rmwWrEn_q <= '0;
      wbData_q  <= '0;
      rfWrEn_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rfWrEn_q  <= 1'b0;
      rmwWrEn_q <= '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (bus.mem_mode)
              MODE_NONE: begin
                rfWrEn_q <= bus.wb_req;
                if (bus.wb_req) wbData_q <= bus.alu_result;
              end
              MODE_LD: begin
                bank_q  <= bankIn;
                state_q <= LD_WAIT;
              end
              MODE_ST: ;
              MODE_LDI: begin
                rfWrEn_q <= 1'b1;
                wbData_q <= bus.data_s2;
              end
              MODE_RMW: begin
                bank_q   <= bankIn;
                addr_q   <= bus.data_s1[ADDR_W-1:0];
                addend_q <= bus.data_s2;
                state_q  <= RMW_WAIT;
              end
              default: err_q <= 1'b1;
            endcase
          end
        end
        LD_WAIT: begin
          wbData_q <= rdSel;
          rfWrEn_q <= 1'b1;
          state_q  <= IDLE;
        end
        // Sum is registered once and feeds both the bank write and the write-back.
        RMW_WAIT: begin
          rmwData_q <= sum;
          rmwWrEn_q <= hotQ;
          wbData_q  <= sum;
          rfWrEn_q  <= 1'b1;
          state_q   <= RMW_WR;
        end
        RMW_WR:  state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef DSP_MEM_PERF_CNT_EN
  logic [31:0] stallCnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt_q <= '0;
    end else if (bus.in_valid && !bus.in_ready && (stallCnt_q != 32'hFFFF_FFFF)) begin
      stallCnt_q <= stallCnt_q + 32'd1;
    end
  end

  assign perf_stall_cnt = stallCnt_q;
`endif
endmodule
